// File: rtl/bitsum_requester.sv
// Initiator for a start/finish compute core: takes operands on a valid/ready stream, holds each
// one on the core as a start request, and returns the captured result (or a timeout marker).
`timescale 1ns / 1ps

module bitsum_requester #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RESW    = 32,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             core_start,
  output logic [WIDTH-1:0] core_in,
  input  logic             core_finish,
  input  logic [RESW-1:0]  core_result,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [RESW-1:0]  m_data,
  output logic             m_timeout,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int unsigned GcW = $clog2(GAP + 1);
  localparam int unsigned RcW = $clog2(TIMEOUT);

  localparam logic [GcW-1:0] GapMax  = GcW'(GAP);
  localparam logic [GcW-1:0] GapLast = GcW'(GAP - 1);
  localparam logic [RcW-1:0] ReqLast = RcW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGap, StReq, StOut} state_e;

  state_e           state_q;
  logic [GcW-1:0]   gap_cnt_q;
  logic [RcW-1:0]   req_cnt_q;
  logic [WIDTH-1:0] core_in_q;
  logic [RESW-1:0]  m_data_q;
  logic             m_timeout_q;
  logic [7:0]       err_count_q;
  logic             fin_qual;

  // A finish seen on the first request edge may belong to the previous transaction.
  assign fin_qual = core_finish && (req_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      gap_cnt_q   <= '0;
      req_cnt_q   <= '0;
      core_in_q   <= '0;
      m_data_q    <= '0;
      m_timeout_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            core_in_q <= s_data;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q != GapMax) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
          // A finish still high from the last request keeps us parked here.
          if ((gap_cnt_q >= GapLast) && !core_finish) begin
            req_cnt_q <= '0;
            state_q   <= StReq;
          end
        end
        StReq: begin
          req_cnt_q <= req_cnt_q + 1'b1;
          if (fin_qual) begin
            m_data_q    <= core_result;
            m_timeout_q <= 1'b0;
            state_q     <= StOut;
          end else if (req_cnt_q == ReqLast) begin
            m_data_q    <= '0;
            m_timeout_q <= 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
            state_q <= StOut;
          end
        end
        StOut: begin
          if (m_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready    = (state_q == StIdle) && rst;
  assign core_start = (state_q == StReq);
  assign m_valid    = (state_q == StOut);
  assign busy       = (state_q != StIdle);
  assign core_in    = core_in_q;
  assign m_data     = m_data_q;
  assign m_timeout  = m_timeout_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_bitsum_requester.sv
// Randomized bench for bitsum_requester: a small core model answers requests and a
// transaction-level model predicts start latency, request length, result and error count.
`timescale 1ns / 1ps

module tb_bitsum_requester;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned RESW    = 32;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             core_start;
  logic [WIDTH-1:0] core_in;
  logic             core_finish;
  logic [RESW-1:0]  core_result;
  logic             m_valid;
  logic             m_ready;
  logic [RESW-1:0]  m_data;
  logic             m_timeout;
  logic             busy;
  logic [7:0]       err_count;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cur_lat     = -1;
  int   age         = 0;
  int   low_run     = 100;
  int   err_exp     = 0;
  int   n;
  logic model_fin   = 1'b0;
  logic ovr_en      = 1'b0;
  logic [WIDTH-1:0] ops [9];

  always #5 clk = ~clk;

  bitsum_requester #(
    .WIDTH  (WIDTH),
    .RESW   (RESW),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .core_start (core_start),
    .core_in    (core_in),
    .core_finish(core_finish),
    .core_result(core_result),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_timeout  (m_timeout),
    .busy       (busy),
    .err_count  (err_count)
  );

  // Core behaviour: bit count of the operand, tagged so zero operands give a nonzero result.
  function automatic logic [RESW-1:0] core_fn(input logic [WIDTH-1:0] x);
    logic [RESW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r += RESW'(x[i]);
    return r ^ RESW'(32'h8A);
  endfunction

  assign core_finish = ovr_en | model_fin;
  assign core_result = core_fn(core_in);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; the core model raises finish lat cycles after start and holds it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (core_start) begin
      age++;
    end else begin
      age = 0;
      low_run++;
    end
    model_fin = core_start && (cur_lat >= 0) && (age >= cur_lat + 1);
  endtask

  // lat < 0: core never finishes; stale: cycles finish is held high after accept;
  // pulse: finish high during the first request cycle only; bp: cycles m_ready held low.
  task automatic run_txn(input logic [WIDTH-1:0] op, input int lat, input int stale,
                         input bit pulse, input int bp);
    int n_lat, h, eff, exp_h, exp_lat;
    bit to;
    logic [RESW-1:0] exp_d;
    eff     = (lat < 1) ? 1 : lat;
    to      = !((lat >= 0) && (eff <= int'(TIMEOUT) - 1));
    exp_h   = to ? int'(TIMEOUT) : eff + 1;
    exp_lat = ((stale > 0) && (stale + 1 > int'(GAP))) ? stale + 1 : int'(GAP);
    exp_d   = to ? '0 : core_fn(op);
    cur_lat = lat;

    chk("idle_s_ready", s_ready, 1);
    s_valid = 1'b1;
    s_data  = op;
    tick();
    s_valid = 1'b0;
    s_data  = $urandom();
    ovr_en  = (stale > 0);
    n_lat   = 0;
    while (!core_start && n_lat < 50) begin
      tick();
      n_lat++;
      if (n_lat >= stale) ovr_en = 1'b0;
    end
    chk("start_latency", n_lat, exp_lat);
    chk("start_low_gap", low_run >= int'(GAP), 1);
    low_run = 0;

    ovr_en = pulse;
    h = 0;
    while (core_start && h < int'(TIMEOUT) + 5) begin
      chk("core_in_held", core_in, op);
      tick();
      h++;
      ovr_en = 1'b0;
    end
    chk("start_high_cycles", h, exp_h);
    if (to) err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    chk("m_valid", m_valid, 1);
    chk("m_data", m_data, exp_d);
    chk("m_timeout", m_timeout, to);
    chk("err_count", err_count, err_exp);

    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, exp_d);
      chk("bp_m_timeout", m_timeout, to);
      chk("bp_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("ret_m_valid", m_valid, 0);
    chk("ret_s_ready", s_ready, 1);
    chk("ret_busy", busy, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_timeout", m_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b1;
    tick();

    // Normal request, then stale finish and first-cycle finish pulse.
    run_txn(32'h8000_0800, 3, 0, 0, 0);
    run_txn($urandom(), 4, 6, 0, 0);
    run_txn($urandom(), 5, 0, 1, 0);
    run_txn($urandom(), 0, 0, 0, 0);

    // Timeouts and the finish-on-last-edge boundary.
    run_txn($urandom(), -1, 0, 0, 0);
    run_txn($urandom(), 15, 0, 0, 0);
    run_txn($urandom(), 16, 0, 0, 0);
    for (int i = 0; i < 300; i++) run_txn($urandom(), -1, 0, 0, 0);
    run_txn($urandom(), 15, 0, 0, 0);

    // Back-pressure on both a good result and a timeout.
    run_txn($urandom(), 2, 0, 0, 5);
    run_txn($urandom(), -1, 0, 0, 5);

    // Reset in the middle of a request.
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    tick();
    s_valid = 1'b0;
    cur_lat = -1;
    n = 0;
    while (!core_start && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    chk("mid_core_start", core_start, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_core_start", core_start, 0);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_err_count", err_count, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_core_in", core_in, 0);
    err_exp = 0;
    run_txn(32'hCAFE_F00D, 7, 0, 0, 1);

    // Operand stream with random latency and back-pressure.
    ops[0] = 32'h0000_0000;
    ops[1] = 32'h8000_0000;
    ops[2] = 32'hFFFF_FFFF;
    ops[3] = 32'h00FF_00FF;
    ops[4] = 32'h0F0F_0F0F;
    ops[5] = 32'hAAAA_AAAA;
    ops[6] = 32'h5555_5555;
    ops[7] = 32'h0000_0001;
    ops[8] = $urandom();
    for (int i = 0; i < 9; i++) begin
      run_txn(ops[i], int'($urandom_range(1, 14)), 0, 0, int'($urandom_range(0, 4)));
    end
    chk("stream_err_count", err_count, 0);

    // Mixed random traffic, including stale finishes and occasional timeouts.
    for (int i = 0; i < 20; i++) begin
      run_txn($urandom(), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
